dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data memory between two requesters: port 0 (CPU load/store path) and port 1 (loader/debug DMA).
- Sits between the PikaRISC core's dmem_* bus and dataMem.
- Registered ownership with round-robin selection when idle and a burst cap to prevent starvation.
- Memory read is combinational; read data is returned registered one cycle after the grant cycle.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_BURST, 4, max consecutive transfers by one owner while the other port is requesting (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req0  in  1  port 0 transfer request
- addr0  in  ADDR_W  port 0 address
- we0  in  1  port 0 write enable (1=write, 0=read)
- wdata0  in  DATA_W  port 0 write data
- gnt0  out  1  port 0 transfer performed this cycle
- rdata0  out  DATA_W  port 0 registered read data
- rvalid0  out  1  rdata0 valid (one-cycle pulse)
- req1, addr1, we1, wdata1, gnt1, rdata1, rvalid1  as above, for port 1
- mem_addr  out  ADDR_W  to dataMem addr
- mem_write_en  out  1  to dataMem write_en
- mem_wdata  out  DATA_W  to dataMem data_in
- mem_rdata  in  DATA_W  from dataMem data_out

Behaviour:
- State: owner ∈ {NONE, P0, P1} (2-bit reg); last (1 bit, last port served); burst_cnt (clog2(MAX_BURST)+1 bits).
- Reset (reset=0, async): owner=NONE, last=1 (so P0 wins the first tie), burst_cnt=0, rdata*=0, rvalid*=0.
  - gnt* and mem_write_en are forced low while owner=NONE.
  - Reset mid-transfer drops the transfer; no write occurs after reset is asserted.
- Grant (combinational from registers): gntN = (owner==PN) & reqN.
- Memory mux:
  - owner=P0 → mem_* = addr0/wdata0, mem_write_en = we0 & req0.
  - owner=P1 → same, from port 1.
  - owner=NONE → mem_addr=0, mem_wdata=0, mem_write_en=0.
- A transfer occurs in every cycle with gntN=1. Writes commit at that clock edge.
- Read return: at each edge, rdataN <= mem_rdata and rvalidN <= gntN & ~weN. rvalidN is otherwise 0; rdataN holds its last value.
- Requester handshake:
  - Hold req/addr/we/wdata stable until gnt is seen.
  - Keeping req high after a gnt cycle requests the next transfer; back-to-back transfers then run at 1 per cycle.
- Next-owner rules, evaluated at each edge, first match wins:
  1. owner=NONE: both req → port ≠ last; one req → that port; none → NONE. burst_cnt=0.
  2. owner=PN, reqN=0 → other port if it requests, else NONE. burst_cnt=0.
  3. owner=PN, transfer done, burst_cnt+1==MAX_BURST, other port requesting → switch owner. burst_cnt=0.
  4. owner=PN, transfer done, otherwise → keep owner; burst_cnt = min(burst_cnt+1, MAX_BURST-1) when the other port is idle.
- last updates to N on every cycle with gntN=1.
- Latency: from owner=NONE, req asserted in cycle t → gnt in cycle t+1 → rvalid in t+2. An owner requesting again gets gnt with 0 extra cycles.
- MAX_BURST=1 gives strict alternation under contention.
- gnt0 and gnt1 are never both 1 (mutually exclusive by construction).

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined:
  - Adds output stall_cnt (16 bits).
  - Increments on each cycle where (req0 & ~gnt0) | (req1 & ~gnt1); saturates at 0xFFFF.
  - Cleared by reset.
  - Adds input stall_clr (1 bit); synchronous clear when high, and clear has priority over increment.
- Undefined: neither port exists; no counter logic.

Test Plan:
- Reset/idle: hold reset=0 for 2 clk, then release with no req → gnt0=gnt1=0, mem_write_en=0, mem_addr=0, rvalid*=0.
- Single read: dataMem[0x10]=0xDEADBEEF; req0=1, we0=0, addr0=0x10 at t → gnt0=1 at t+1, rvalid0=1 with rdata0=0xDEADBEEF at t+2.
- Single write: req1=1, we1=1, addr1=0x20, wdata1=0x12345678 → one cycle with mem_write_en=1 during gnt1; a later port 0 read of 0x20 returns 0x12345678.
- Tie plus burst cap: req0 and req1 both high continuously from reset, MAX_BURST=4 → grant sequence P0×4, P1×4, P0×4…; never both gnt high.
- Release handoff: P1 owns, drops req1 while req0 is high → gnt0 in the next cycle with no idle gap; burst_cnt restarts, so P0 gets a full 4 transfers.
- Async reset mid-burst: assert reset between edges while gnt1=1, we1=1 → all outputs zero immediately, memory unchanged at the next edge. With DMEM_ARB_STATS_EN, 10 contended cycles give stall_cnt=10, then stall_clr gives 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data memory arbiter: registered ownership, round-robin on ties, burst cap under contention.
// Optional stall statistics counter is enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              we0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic [DATA_W-1:0] rdata0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              we1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic [DATA_W-1:0] rdata1,
    output logic              rvalid1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    input  logic              stall_clr,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W:0]   BURST_LIM = (CNT_W + 1)'(MAX_BURST);
    localparam logic [CNT_W-1:0] BURST_TOP = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

    owner_t           owner;
    logic             last;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W:0]   burst_nxt;
    logic             burst_full;
    logic [CNT_W-1:0] burst_sat;

    assign gnt0 = (owner == OWN_P0) & req0;
    assign gnt1 = (owner == OWN_P1) & req1;

    // One extra bit on the increment so the cap compare cannot wrap for any MAX_BURST.
    assign burst_nxt  = {1'b0, burst_cnt} + 1'b1;
    assign burst_full = (burst_nxt >= BURST_LIM);
    assign burst_sat  = burst_full ? BURST_TOP : burst_nxt[CNT_W-1:0];

    always_comb begin
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_write_en = 1'b0;
        case (owner)
            OWN_P0: begin
                mem_addr     = addr0;
                mem_wdata    = wdata0;
                mem_write_en = we0 & req0;
            end
            OWN_P1: begin
                mem_addr     = addr1;
                mem_wdata    = wdata1;
                mem_write_en = we1 & req1;
            end
            default: begin
                mem_addr     = '0;
                mem_wdata    = '0;
                mem_write_en = 1'b0;
            end
        endcase
    end

    // Ownership only changes at an edge, so a newly idle arbiter costs one cycle before the first grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner     <= OWN_NONE;
            last      <= 1'b1;
            burst_cnt <= '0;
            rdata0    <= '0;
            rdata1    <= '0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (gnt0 & ~we0) rdata0 <= mem_rdata;
            if (gnt1 & ~we1) rdata1 <= mem_rdata;

            if (gnt0)      last <= 1'b0;
            else if (gnt1) last <= 1'b1;

            case (owner)
                OWN_NONE: begin
                    burst_cnt <= '0;
                    if (req0 && req1) owner <= last ? OWN_P0 : OWN_P1;
                    else if (req0)    owner <= OWN_P0;
                    else if (req1)    owner <= OWN_P1;
                    else              owner <= OWN_NONE;
                end
                OWN_P0: begin
                    if (!req0) begin
                        burst_cnt <= '0;
                        owner     <= req1 ? OWN_P1 : OWN_NONE;
                    end else if (req1 && burst_full) begin
                        burst_cnt <= '0;
                        owner     <= OWN_P1;
                    end else begin
                        burst_cnt <= burst_sat;
                    end
                end
                OWN_P1: begin
                    if (!req1) begin
                        burst_cnt <= '0;
                        owner     <= req0 ? OWN_P0 : OWN_NONE;
                    end else if (req0 && burst_full) begin
                        burst_cnt <= '0;
                        owner     <= OWN_P0;
                    end else begin
                        burst_cnt <= burst_sat;
                    end
                end
                default: begin
                    burst_cnt <= '0;
                    owner     <= OWN_NONE;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic stall_now;

    assign stall_now = (req0 & ~gnt0) | (req1 & ~gnt1);

    // Saturating count of cycles in which any requester was kept waiting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall_clr) begin
            stall_cnt <= '0;
        end else if (stall_now && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a small behavioural data memory.
// Define DMEM_ARB_STATS_EN to also exercise the stall counter.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, rvalid0, gnt1, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write_en;
`ifdef DMEM_ARB_STATS_EN
    logic        stall_clr;
    logic [15:0] stall_cnt;
`endif

    logic [31:0] mem [0:255];
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    int          write_count = 0;
    int          assert_count = 0;
    int          fail_count = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0),
        .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
        .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1),
        .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
        .mem_addr(mem_addr), .mem_write_en(mem_write_en),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        , .stall_clr(stall_clr), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:0]];

    // Data memory: preload port for the bench, write port driven by the arbiter.
    always @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        if (mem_write_en) begin
            mem[mem_addr[7:0]] <= mem_wdata;
            write_count <= write_count + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int port, input logic req, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            req0 = req; we0 = we; addr0 = addr; wdata0 = wdata;
        end else begin
            req1 = req; we1 = we; addr1 = addr; wdata1 = wdata;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
`ifdef DMEM_ARB_STATS_EN
        stall_clr = 1'b0;
`endif
        load_en = 1'b1; load_addr = 8'h10; load_data = 32'hDEADBEEF;
        tick;
        load_addr = 8'h30; load_data = 32'hAAAA5555;
        tick;
        load_en = 1'b0;
        checkOutput("rst_gnt0", {31'b0, gnt0}, 32'd0);
        checkOutput("rst_rvalid0", {31'b0, rvalid0}, 32'd0);

        // Idle after reset: address mux must stay at zero even with a stale addr0.
        applyStimulus(0, 1'b0, 1'b0, 32'h55, 32'h0);
        reset = 1'b1;
        tick;
        checkOutput("idle_gnt0", {31'b0, gnt0}, 32'd0);
        checkOutput("idle_gnt1", {31'b0, gnt1}, 32'd0);
        checkOutput("idle_wen", {31'b0, mem_write_en}, 32'd0);
        checkOutput("idle_addr", mem_addr, 32'h0);
        checkOutput("idle_rvalid0", {31'b0, rvalid0}, 32'd0);
        checkOutput("idle_rvalid1", {31'b0, rvalid1}, 32'd0);

        // Single read on port 0.
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        checkOutput("rd_no_gnt_yet", {31'b0, gnt0}, 32'd0);
        tick;
        checkOutput("rd_gnt0", {31'b0, gnt0}, 32'd1);
        checkOutput("rd_addr", mem_addr, 32'h10);
        checkOutput("rd_wen", {31'b0, mem_write_en}, 32'd0);
        tick;
        applyStimulus(0, 1'b0, 1'b0, 32'h10, 32'h0);
        checkOutput("rd_rvalid0", {31'b0, rvalid0}, 32'd1);
        checkOutput("rd_rdata0", rdata0, 32'hDEADBEEF);
        tick;
        checkOutput("rd_rvalid0_pulse", {31'b0, rvalid0}, 32'd0);
        checkOutput("rd_rdata0_hold", rdata0, 32'hDEADBEEF);

        // Single write on port 1, then read it back through port 0.
        applyStimulus(1, 1'b1, 1'b1, 32'h20, 32'h12345678);
        tick;
        checkOutput("wr_gnt1", {31'b0, gnt1}, 32'd1);
        checkOutput("wr_gnt0", {31'b0, gnt0}, 32'd0);
        checkOutput("wr_wen", {31'b0, mem_write_en}, 32'd1);
        checkOutput("wr_addr", mem_addr, 32'h20);
        checkOutput("wr_wdata", mem_wdata, 32'h12345678);
        tick;
        applyStimulus(1, 1'b0, 1'b0, 32'h20, 32'h0);
        #1;
        checkOutput("wr_no_rvalid1", {31'b0, rvalid1}, 32'd0);
        checkOutput("wr_count", write_count, 32'd1);
        checkOutput("wr_wen_drop", {31'b0, mem_write_en}, 32'd0);
        tick;
        applyStimulus(0, 1'b1, 1'b0, 32'h20, 32'h0);
        tick;
        checkOutput("rb_gnt0", {31'b0, gnt0}, 32'd1);
        tick;
        applyStimulus(0, 1'b0, 1'b0, 32'h20, 32'h0);
        checkOutput("rb_rvalid0", {31'b0, rvalid0}, 32'd1);
        checkOutput("rb_rdata0", rdata0, 32'h12345678);
        tick;

        // Contention from reset: P0 wins the tie, then bursts of 4 alternate.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 32'h20, 32'h0);
        #1;
        checkOutput("tie_none_gnt0", {31'b0, gnt0}, 32'd0);
        checkOutput("tie_none_gnt1", {31'b0, gnt1}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick;
            checkOutput($sformatf("tie_gnt0_%0d", k), {31'b0, gnt0}, (k < 4) ? 32'd1 : 32'd0);
            checkOutput($sformatf("tie_gnt1_%0d", k), {31'b0, gnt1}, (k < 4) ? 32'd0 : 32'd1);
        end

        // P1 releases mid-burst; P0 takes over and gets a fresh burst of 4.
        tick;
        applyStimulus(1, 1'b0, 1'b0, 32'h20, 32'h0);
        #1;
        checkOutput("ho_gap_gnt0", {31'b0, gnt0}, 32'd0);
        checkOutput("ho_gap_gnt1", {31'b0, gnt1}, 32'd0);
        tick;
        applyStimulus(1, 1'b1, 1'b0, 32'h20, 32'h0);
        #1;
        for (int j = 0; j < 5; j++) begin
            if (j > 0) tick;
            checkOutput($sformatf("ho_gnt0_%0d", j), {31'b0, gnt0}, (j < 4) ? 32'd1 : 32'd0);
            checkOutput($sformatf("ho_gnt1_%0d", j), {31'b0, gnt1}, (j < 4) ? 32'd0 : 32'd1);
        end
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick;
        tick;

        // Asynchronous reset while a port 1 write is being granted.
        applyStimulus(1, 1'b1, 1'b1, 32'h30, 32'h0BADF00D);
        tick;
        checkOutput("ar_gnt1", {31'b0, gnt1}, 32'd1);
        checkOutput("ar_wen", {31'b0, mem_write_en}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("ar_gnt1_low", {31'b0, gnt1}, 32'd0);
        checkOutput("ar_wen_low", {31'b0, mem_write_en}, 32'd0);
        checkOutput("ar_addr_zero", mem_addr, 32'h0);
        checkOutput("ar_wdata_zero", mem_wdata, 32'h0);
        checkOutput("ar_rdata0_zero", rdata0, 32'h0);
        checkOutput("ar_rvalid1", {31'b0, rvalid1}, 32'd0);
        tick;
        checkOutput("ar_mem_kept", mem[8'h30], 32'hAAAA5555);
        checkOutput("ar_write_count", write_count, 32'd1);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        tick;

`ifdef DMEM_ARB_STATS_EN
        // Every contended cycle leaves one port (or both, while idle) waiting.
        checkOutput("st_start", {16'b0, stall_cnt}, 32'd0);
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 32'h20, 32'h0);
        for (int s = 0; s < 10; s++) tick;
        checkOutput("st_count10", {16'b0, stall_cnt}, 32'd10);
        stall_clr = 1'b1;
        tick;
        checkOutput("st_cleared", {16'b0, stall_cnt}, 32'd0);
        stall_clr = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
